// File: rtl/icache_pkg.sv
// icache_pkg
//   Shared types and helpers for the instruction fetch unit.
//   - fetch_state_t : fetch controller states (LOOKUP, FILL)
//   - NOP           : instruction presented while hit is low
//   - calc_off_w / calc_idx_w / calc_tag_w : address field widths derived
//     from the cache geometry (16-bit word addresses)
package icache_pkg;

    typedef enum logic [0:0] {
        LOOKUP = 1'b0,
        FILL   = 1'b1
    } fetch_state_t;

    localparam logic [15:0] NOP = 16'h0000;

    function automatic int calc_off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int calc_idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int calc_tag_w(input int num_lines, input int words_per_line);
        return 16 - $clog2(num_lines) - $clog2(words_per_line);
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// icache_line_array
//   Valid / tag / data storage of the direct-mapped instruction cache.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset (clears valid bits only)
//     index        : line selected for both read and write
//     rd_offset    : word within the line for the combinational read
//     rd_valid, rd_tag, rd_data : combinational read results
//     word_wr_en, wr_offset, wr_data : synchronous single-word write
//     tag_wr_en, wr_tag : synchronous tag write, also sets the line valid
//     inval_en     : synchronous clear of the selected line's valid bit
//   The read port is combinational so that hit can be resolved in the same
//   cycle the PC is presented.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4,
    localparam int OFF_W = calc_off_w(WORDS_PER_LINE),
    localparam int IDX_W = calc_idx_w(NUM_LINES),
    localparam int TAG_W = calc_tag_w(NUM_LINES, WORDS_PER_LINE)
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] index,
    input  logic [OFF_W-1:0] rd_offset,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [15:0]      rd_data,
    input  logic             word_wr_en,
    input  logic [OFF_W-1:0] wr_offset,
    input  logic [15:0]      wr_data,
    input  logic             tag_wr_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             inval_en
);

    logic [15:0]          data_mem [NUM_LINES*WORDS_PER_LINE];
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_reg;

    // Tag and data contents are meaningless until valid is set, so they
    // carry no reset.
    always_ff @(posedge clk) begin
        if (word_wr_en) begin
            data_mem[{index, wr_offset}] <= wr_data;
        end
        if (tag_wr_en) begin
            tag_mem[index] <= wr_tag;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[gi] <= 1'b0;
                end else if (index == IDX_W'(gi)) begin
                    if (tag_wr_en) begin
                        valid_reg[gi] <= 1'b1;
                    end else if (inval_en) begin
                        valid_reg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign rd_valid = valid_reg[index];
    assign rd_tag   = tag_mem[index];
    assign rd_data  = data_mem[{index, rd_offset}];

endmodule

// File: rtl/icache_fetch_unit.sv
// icache_fetch_unit
//   Instruction-supply stage: PC register plus a direct-mapped instruction
//   cache refilled one word at a time from a slow instruction memory.
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset
//     pc_src         : take-branch request (sampled only when hit=1)
//     branch_target  : branch target word address
//     instr_out      : fetched instruction, NOP when hit=0
//     hit            : instr_out valid; downstream pipeline advance enable
//     pc_plus1_out   : PC+1 (modulo 2^16)
//     mem_req, mem_addr : line-fill word request and its word address
//     mem_ack, mem_rdata: request accepted with data this cycle
module icache_fetch_unit
    import icache_pkg::*;
#(
    parameter int          NUM_LINES      = 8,
    parameter int          WORDS_PER_LINE = 4,
    parameter logic [15:0] RESET_PC       = 16'h0000
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_src,
    input  logic [15:0] branch_target,
    output logic [15:0] instr_out,
    output logic        hit,
    output logic [15:0] pc_plus1_out,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);

    localparam int OFF_W = calc_off_w(WORDS_PER_LINE);
    localparam int IDX_W = calc_idx_w(NUM_LINES);
    localparam int TAG_W = calc_tag_w(NUM_LINES, WORDS_PER_LINE);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    fetch_state_t     state_reg;
    logic [15:0]      pc_reg;
    logic [OFF_W-1:0] cnt_reg;

    logic [OFF_W-1:0] pc_offset;
    logic [IDX_W-1:0] pc_index;
    logic [TAG_W-1:0] pc_tag;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [15:0]      rd_data;

    logic             lookup_hit;
    logic             fill_ack;
    logic             fill_last;
    logic             miss_start;

    assign pc_offset = pc_reg[OFF_W-1:0];
    assign pc_index  = pc_reg[OFF_W+IDX_W-1:OFF_W];
    assign pc_tag    = pc_reg[15:OFF_W+IDX_W];

    assign lookup_hit = (state_reg == LOOKUP) && rd_valid && (rd_tag == pc_tag);
    assign miss_start = (state_reg == LOOKUP) && !lookup_hit;
    assign fill_ack   = (state_reg == FILL) && mem_ack;
    assign fill_last  = fill_ack && (cnt_reg == LAST_WORD);

    icache_line_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_line_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .index      (pc_index),
        .rd_offset  (pc_offset),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .word_wr_en (fill_ack),
        .wr_offset  (cnt_reg),
        .wr_data    (mem_rdata),
        .tag_wr_en  (fill_last),
        .wr_tag     (pc_tag),
        .inval_en   (miss_start)
    );

    // PC is frozen for the whole refill; the line being filled is always the
    // one addressed by the current PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= LOOKUP;
            pc_reg    <= RESET_PC;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                LOOKUP: begin
                    if (lookup_hit) begin
                        pc_reg <= pc_src ? branch_target : pc_reg + 16'd1;
                    end else begin
                        state_reg <= FILL;
                        cnt_reg   <= '0;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        // Counter wraps to zero on the last word.
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == LAST_WORD) begin
                            state_reg <= LOOKUP;
                        end
                    end
                end
                default: state_reg <= LOOKUP;
            endcase
        end
    end

    // mem_req is a straight decode of the state register, so it falls as
    // soon as rst_n asserts.
    assign mem_req      = (state_reg == FILL);
    assign mem_addr     = {pc_reg[15:OFF_W], cnt_reg};
    assign hit          = lookup_hit;
    assign instr_out    = lookup_hit ? rd_data : NOP;
    assign pc_plus1_out = pc_reg + 16'd1;

endmodule

// File: doc/icache_fetch_unit.md
Name: icache_fetch_unit

Overview:
- Upstream instruction-supply stage for the 16-bit pipelined processor. Owns the PC register and a direct-mapped instruction cache.
- Delivers one instruction per cycle on a hit, with a hit qualifier that the IF/ID, ID/EX and EX/MEM registers use as their advance enable.
- On a miss it stalls the pipeline, because hit is low. It then refills one line from a slow word-wide instruction memory through a req/ack handshake.

Parameters:
- NUM_LINES, 8, number of cache lines; must be a power of 2, minimum 2.
- WORDS_PER_LINE, 4, 16-bit words per line; must be a power of 2, minimum 2.
- RESET_PC, 16'h0000, PC value loaded by reset.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pc_src  in  1  take-branch request from the memory stage
- branch_target  in  16  branch target word address from EX/MEM
- instr_out  out  16  fetched instruction; 16'h0000 (NOP) when hit=0
- hit  out  1  instr_out valid this cycle; pipeline advances only when 1
- pc_plus1_out  out  16  PC+1, combinational, for IF/ID
- mem_req  out  1  line-fill word request
- mem_addr  out  16  word address being requested
- mem_ack  in  1  mem_rdata valid; consumes the current request
- mem_rdata  in  16  instruction word from instruction memory

Behaviour:
- Addressing:
  - PC is a word address. OFF = log2(WORDS_PER_LINE), IDX = log2(NUM_LINES).
  - offset = pc[OFF-1:0]; index = pc[OFF+IDX-1:OFF]; tag = pc[15:OFF+IDX].
- Reset (async assert, sync release):
  - PC = RESET_PC, all valid bits = 0, state = LOOKUP, fill counter = 0.
  - mem_req = 0, hit = 0, instr_out = 0, pc_plus1_out = RESET_PC+1.
  - Tag and data arrays are not reset.
- State LOOKUP:
  - hit = valid[index] && tag_arr[index]==tag, combinational within the same cycle.
  - On hit: instr_out = data[index][offset]. At the clock edge, PC <= pc_src ? branch_target : PC+1.
  - On miss: hit = 0 and instr_out = 0. At the clock edge, go to FILL with fill counter = 0 and valid[index] cleared.
- State FILL:
  - mem_req = 1; mem_addr = {PC[15:OFF], cnt}; hit = 0.
  - Each cycle with mem_ack=1: data[index][cnt] <= mem_rdata and cnt++. mem_ack may stay high on consecutive cycles, one word per cycle.
  - While mem_ack=0: mem_req and mem_addr stay stable.
  - On the ack of word WORDS_PER_LINE-1: write the tag, set valid, drop mem_req at the next edge, return to LOOKUP. The first possible hit is the cycle after the last ack.
  - The PC is not changed during FILL.
- Miss latency: 1 lookup cycle + WORDS_PER_LINE acks + 1 lookup cycle.
- pc_src / branch_target handling:
  - Sampled only on cycles with hit=1. EX/MEM is frozen by hit=0, so a pending pc_src stays asserted until the refill completes.
  - pc_src=1 on a hit overrides PC+1. The redirect target may itself miss.
- Wrap-around: PC+1 is modulo 2^16, so 16'hFFFF becomes 16'h0000. Fill addresses never cross a line boundary.
- Reset asserted mid-FILL: the fill is abandoned immediately, mem_req drops asynchronously and all lines are invalid. The memory side must tolerate a dropped request.
- mem_ack while in LOOKUP is ignored.

Decomposition:
- Shared package `icache_pkg`:
  - state enum {LOOKUP, FILL};
  - NOP constant 16'h0000;
  - functions deriving OFF, IDX and tag width from the parameters.
- Sub-module `icache_line_array`: valid, tag and data storage. It has a combinational read port (index, offset) and a synchronous write port (word write, tag write/valid set), plus an async valid clear.
- The FSM, PC register and handshake logic live in the top block.

Test Plan:
- Cold start: release rst_n; memory acks every 2nd cycle with words 0x1000..0x1003.
  - mem_addr must step 0x0000..0x0003.
  - hit must rise exactly 1 cycle after the 4th ack with instr_out = 0x1000.
- Sequential hits: after the cold fill, hold pc_src=0.
  - 4 consecutive cycles must show hit=1, with instr_out 0x1000..0x1003 and pc_plus1_out 0x0001..0x0004.
  - The next cycle must miss at PC 0x0004.
- Conflict eviction: fill line at PC 0x0000, then at 0x0020 (same index), then return to 0x0000.
  - The third access must miss and refill with mem_addr 0x0000..0x0003.
- Branch on hit: pc_src=1, branch_target=0x0013 during a hit cycle.
  - The next PC must be 0x0013 and miss; the fill runs mem_addr 0x0010..0x0013.
  - The first hit must return the word at offset 3.
- Back-to-back acks: mem_ack held high for 4 cycles; the fill must complete in 4 cycles with no dropped or duplicated word.
- Reset mid-fill: assert rst_n=0 after the 2nd ack.
  - mem_req must drop without waiting for a clock, and PC must return to RESET_PC.
  - The next access must miss, including on previously valid lines.
- Wrap-around: run at PC 0xFFFF with a hit; pc_plus1_out must be 0x0000 and the next fetch must be from 0x0000.
